// File: rtl/arch_map_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arch_map_pkg : shared types for the committed architectural map            |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package arch_map_pkg;

  localparam int LREG_W = 5;
  localparam int PREG_W = 8;

  typedef logic [LREG_W-1:0] lreg_t;
  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    logic [15:0] opid;
    lreg_t       lrda;
    preg_t       prda;
    logic        redir;
    logic        rollback;
  } com_bundle_t;

  typedef enum logic [0:0] {
    REC_IDLE    = 1'b0,
    REC_RECOVER = 1'b1
  } rec_state_e;

  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage : arch_map_pkg
`default_nettype wire

// File: rtl/arch_map_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arch_map_if : commit bundle in, register release and map restore out       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface arch_map_if
  import arch_map_pkg::*;
#(
  parameter int cwd = 4,
  parameter int rcw = 4
) ();

  com_bundle_t [cwd-1:0] com_bundle;
  logic        [cwd-1:0] free_valid;
  preg_t       [cwd-1:0] free_preg;
  logic                  rec_busy;
  logic        [rcw-1:0] rec_valid;
  lreg_t       [rcw-1:0] rec_lreg;
  preg_t       [rcw-1:0] rec_preg;

  modport master (
    output com_bundle,
    input  free_valid, free_preg, rec_busy, rec_valid, rec_lreg, rec_preg
  );

  modport slave (
    input  com_bundle,
    output free_valid, free_preg, rec_busy, rec_valid, rec_lreg, rec_preg
  );

endinterface : arch_map_if
`default_nettype wire

// File: rtl/arch_map_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arch_map_fsm : recovery sequencer, walks the map one rcw-wide beat a cycle |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module arch_map_fsm
  import arch_map_pkg::*;
#(
  parameter  int lregs = 32,
  parameter  int rcw   = 4,
  localparam int CNT_W = cnt_width(lregs / rcw)
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              redir_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(lregs / rcw - 1);

  rec_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REC_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      REC_IDLE: begin
        if (redir_i) begin
          state_d = REC_RECOVER;
          cnt_d   = '0;
        end
      end
      REC_RECOVER: begin
        // A fresh redirect restarts the walk, even on the final beat
        if (redir_i) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_BEAT) begin
          state_d = REC_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = REC_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q == REC_RECOVER);
  assign cnt_o  = cnt_q;

endmodule : arch_map_fsm
`default_nettype wire

// File: rtl/arch_map.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arch_map : committed logical->physical map, register release and recovery  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module arch_map
  import arch_map_pkg::*;
#(
  parameter int cwd   = 4,
  parameter int lregs = 32,
  parameter int pregs = 128,
  parameter int rcw   = 4
) (
  input wire        clk,
  input wire        rst,
  arch_map_if.slave bus
);

  localparam int CNT_W = cnt_width(lregs / rcw);

  preg_t            map_q [lregs];
  preg_t            map_d [lregs];
  logic [cwd-1:0]   rel_valid_d, free_valid_q;
  preg_t [cwd-1:0]  rel_preg_d, free_preg_q;
  logic             rec_busy;
  logic [CNT_W-1:0] rec_cnt;

  // Lanes apply in order so a lane sees the prda of any lower lane that
  // already wrote the same lrda this cycle; the highest lane wins the map.
  always_comb begin
    map_d       = map_q;
    rel_valid_d = '0;
    rel_preg_d  = '0;
    for (int i = 0; i < cwd; i++) begin
      if (bus.com_bundle[i].rollback) begin
        if (bus.com_bundle[i].lrda != '0 && bus.com_bundle[i].prda != '0) begin
          rel_valid_d[i] = 1'b1;
          rel_preg_d[i]  = bus.com_bundle[i].prda;
        end
      end else if (bus.com_bundle[i].opid[15] && bus.com_bundle[i].lrda != '0) begin
        rel_valid_d[i]                   = 1'b1;
        rel_preg_d[i]                    = map_d[bus.com_bundle[i].lrda];
        map_d[bus.com_bundle[i].lrda]    = bus.com_bundle[i].prda;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < lregs; l++) begin
        map_q[l] <= preg_t'(l % pregs);
      end
      free_valid_q <= '0;
      free_preg_q  <= '0;
    end else begin
      map_q        <= map_d;
      free_valid_q <= rel_valid_d;
      free_preg_q  <= rel_preg_d;
    end
  end

  arch_map_fsm #(
    .lregs (lregs),
    .rcw   (rcw)
  ) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .redir_i (bus.com_bundle[0].redir),
    .busy_o  (rec_busy),
    .cnt_o   (rec_cnt)
  );

  // Restore beats read map_d so same-cycle commits are forwarded
  always_comb begin
    lreg_t idx;
    idx           = '0;
    bus.rec_valid = '0;
    bus.rec_lreg  = '0;
    bus.rec_preg  = '0;
    if (rec_busy) begin
      for (int k = 0; k < rcw; k++) begin
        idx              = lreg_t'(int'(rec_cnt) * rcw + k);
        bus.rec_valid[k] = 1'b1;
        bus.rec_lreg[k]  = idx;
        bus.rec_preg[k]  = map_d[idx];
      end
    end
  end

  assign bus.free_valid = free_valid_q;
  assign bus.free_preg  = free_preg_q;
  assign bus.rec_busy   = rec_busy;

endmodule : arch_map
`default_nettype wire

// File: tb/tb_arch_map.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_arch_map : directed + random bundles against a reference map model      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_arch_map;
  import arch_map_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arch_map_if #(.cwd(4), .rcw(4)) intf ();

  arch_map #(
    .cwd   (4),
    .lregs (32),
    .pregs (128),
    .rcw   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  int n_vec  = 0;
  int n_fail = 0;

  int         ref_map [32];
  logic [3:0] exp_fv;
  int         exp_fp  [4];
  bit         busy;
  int         beat;
  com_bundle_t [3:0] bnd;

  function automatic bit commits(input com_bundle_t b);
    return b.opid[15] == 1'b1 && b.rollback == 1'b0 && b.lrda != 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive bnd/rst, check outputs mid-cycle, then advance the model.
  task automatic cycle(input bit r);
    int nm  [32];
    int rel [4];
    logic [3:0] fv;
    int l;
    intf.com_bundle = bnd;
    rst             = r;
    fv              = '0;
    for (int i = 0; i < 4; i++) begin
      rel[i] = 0;
      l      = int'(bnd[i].lrda);
      if (bnd[i].rollback && l != 0 && bnd[i].prda != 0) begin
        fv[i]  = 1'b1;
        rel[i] = int'(bnd[i].prda);
      end else if (commits(bnd[i])) begin
        fv[i]  = 1'b1;
        rel[i] = ref_map[l];
        for (int j = i - 1; j >= 0; j--) begin
          if (commits(bnd[j]) && bnd[j].lrda == bnd[i].lrda) begin
            rel[i] = int'(bnd[j].prda);
            break;
          end
        end
      end
    end
    for (int m = 0; m < 32; m++) begin
      nm[m] = ref_map[m];
      for (int i = 0; i < 4; i++) begin
        if (commits(bnd[i]) && int'(bnd[i].lrda) == m) nm[m] = int'(bnd[i].prda);
      end
    end

    @(negedge clk);
    chk("free_valid", 32'(intf.free_valid), 32'(exp_fv));
    for (int i = 0; i < 4; i++) begin
      if (exp_fv[i]) chk($sformatf("free_preg[%0d]", i), 32'(intf.free_preg[i]), 32'(exp_fp[i]));
    end
    chk("rec_busy", 32'(intf.rec_busy), 32'(busy));
    chk("rec_valid", 32'(intf.rec_valid), busy ? 32'hF : 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rec_lreg[%0d]", k), 32'(intf.rec_lreg[k]), busy ? 32'(beat * 4 + k) : 32'h0);
      chk($sformatf("rec_preg[%0d]", k), 32'(intf.rec_preg[k]), busy ? 32'(nm[beat * 4 + k]) : 32'h0);
    end

    @(posedge clk);
    #1;
    if (r) begin
      for (int m = 0; m < 32; m++) ref_map[m] = m;
      exp_fv = '0;
      busy   = 1'b0;
      beat   = 0;
    end else begin
      ref_map = nm;
      exp_fv  = fv;
      exp_fp  = rel;
      if (bnd[0].redir) begin
        busy = 1'b1;
        beat = 0;
      end else if (busy) begin
        if (beat == 7) begin
          busy = 1'b0;
          beat = 0;
        end else begin
          beat++;
        end
      end
    end
  endtask

  task automatic rand_bnd(input int redir_pct);
    for (int i = 0; i < 4; i++) begin
      bnd[i].opid     = 16'($urandom);
      bnd[i].rollback = ($urandom_range(0, 3) == 0);
      bnd[i].lrda     = lreg_t'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      bnd[i].prda     = preg_t'($urandom_range(0, 127));
      bnd[i].redir    = ($urandom_range(0, 99) < redir_pct);
    end
  endtask

  task automatic recover_all();
    bnd          = '0;
    bnd[0].redir = 1'b1;
    cycle(1'b0);
    bnd = '0;
    repeat (9) cycle(1'b0);
  endtask

  initial begin
    rst             = 1'b1;
    bnd             = '0;
    intf.com_bundle = '0;
    exp_fv          = '0;
    busy            = 1'b0;
    beat            = 0;
    for (int m = 0; m < 32; m++) ref_map[m] = m;
    for (int i = 0; i < 4; i++) exp_fp[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    cycle(1'b1);

    // Single commit lrda 5 -> prda 40
    bnd = '0;
    bnd[0].opid[15] = 1'b1; bnd[0].lrda = 5'd5; bnd[0].prda = 8'd40;
    cycle(1'b0);

    // Two lanes writing lrda 7 in one bundle
    bnd = '0;
    bnd[0].opid[15] = 1'b1; bnd[0].lrda = 5'd7; bnd[0].prda = 8'd50;
    bnd[1].opid[15] = 1'b1; bnd[1].lrda = 5'd7; bnd[1].prda = 8'd51;
    cycle(1'b0);

    // Rollback on lane 2, lrda 0 commit on lane 3
    bnd = '0;
    bnd[2].rollback = 1'b1; bnd[2].lrda = 5'd3; bnd[2].prda = 8'd60;
    bnd[3].opid[15] = 1'b1; bnd[3].lrda = 5'd0; bnd[3].prda = 8'd99;
    cycle(1'b0);
    bnd = '0;
    cycle(1'b0);

    // Full recovery walk
    recover_all();

    // Redirect again on beat 5, commit lrda 9 on beat 2 of the restart
    bnd = '0; bnd[0].redir = 1'b1;
    cycle(1'b0);
    bnd = '0;
    repeat (5) cycle(1'b0);
    bnd[0].redir = 1'b1;
    cycle(1'b0);
    bnd = '0;
    repeat (2) cycle(1'b0);
    bnd[0].opid[15] = 1'b1; bnd[0].lrda = 5'd9; bnd[0].prda = 8'd70;
    cycle(1'b0);
    bnd = '0;
    repeat (6) cycle(1'b0);

    // Reset on beat 3 aborts recovery and restores identity map
    bnd = '0; bnd[0].redir = 1'b1;
    cycle(1'b0);
    bnd = '0;
    repeat (3) cycle(1'b0);
    bnd[1].opid[15] = 1'b1; bnd[1].lrda = 5'd12; bnd[1].prda = 8'd88;
    cycle(1'b1);
    bnd = '0;
    cycle(1'b0);
    recover_all();

    repeat (400) begin
      rand_bnd(4);
      cycle($urandom_range(0, 199) == 0);
    end
    recover_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_arch_map
`default_nettype wire
